// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Owns the fetch address, fetches one instruction word at a time from an
//   instruction memory (request/response, one request outstanding) and hands
//   each word plus its address to decode over a valid/ready handshake.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   redirect_valid   branch/jump taken this cycle; replaces the fetch address
//   redirect_pc      redirect target (low two bits forced to zero)
//   imem_req         request to instruction memory (combinational)
//   imem_addr        word-aligned fetch address
//   imem_ready       memory accepts the request this cycle
//   imem_rvalid      response data valid
//   imem_rdata       instruction word from memory
//   inst_valid       instruction available to decode (combinational)
//   inst_ready       decode accepts the instruction
//   inst_out         buffered instruction word
//   inst_pc          address of inst_out
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // issue request for fetch_pc
    S_WAIT = 2'd1,  // request accepted, awaiting response
    S_HOLD = 2'd2   // instruction buffered, awaiting decode
  } state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic            drop_reg, drop_next;
  logic [XLEN-1:0] inst_out_reg, inst_out_next;
  logic [XLEN-1:0] inst_pc_reg, inst_pc_next;
  logic [XLEN-1:0] redirect_target;

  // Fetch addresses are always word aligned.
  assign redirect_target = redirect_pc & ~(XLEN'(3));

  assign imem_addr = fetch_pc_reg;
  assign inst_out  = inst_out_reg;
  assign inst_pc   = inst_pc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_REQ;
      fetch_pc_reg <= RESET_PC;
      drop_reg     <= 1'b0;
      inst_out_reg <= '0;
      inst_pc_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      drop_reg     <= drop_next;
      inst_out_reg <= inst_out_next;
      inst_pc_reg  <= inst_pc_next;
    end
  end

  // A redirect wins over every other event in every state.
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    drop_next     = drop_reg;
    inst_out_next = inst_out_reg;
    inst_pc_next  = inst_pc_reg;
    imem_req      = 1'b0;
    inst_valid    = 1'b0;

    case (state_reg)
      S_REQ: begin
        imem_req = !redirect_valid;
        if (redirect_valid) begin
          fetch_pc_next = redirect_target;
        end else if (imem_ready) begin
          state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          fetch_pc_next = redirect_target;
          if (imem_rvalid) begin
            // Response for the stale address arrives with the redirect.
            drop_next  = 1'b0;
            state_next = S_REQ;
          end else begin
            // The in-flight response belongs to the old stream; discard it
            // when it shows up.
            drop_next = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (drop_reg) begin
            drop_next  = 1'b0;
            state_next = S_REQ;
          end else begin
            inst_out_next = imem_rdata;
            inst_pc_next  = fetch_pc_reg;
            fetch_pc_next = fetch_pc_reg + XLEN'(4);
            state_next    = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        inst_valid = !redirect_valid;
        if (redirect_valid) begin
          // Buffered instruction is discarded, never transferred.
          fetch_pc_next = redirect_target;
          state_next    = S_REQ;
        end else if (inst_ready) begin
          state_next = S_REQ;
        end
      end

      default: begin
        state_next = S_REQ;
      end
    endcase

    // Handshake outputs stay quiet while reset is asserted.
    if (rst) begin
      imem_req   = 1'b0;
      inst_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: behavioural instruction memory (random
// ready, configurable response latency, data = address + 0x13) and a
// stream-level reference model (delivered pcs advance by 4 from RESET_PC or
// from the last redirect target).  A second instance with RESET_PC at the top
// of the address space shares all inputs to exercise address wrap.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_inst_valid;
  logic [31:0] w_inst_out;
  logic [31:0] w_inst_pc;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h00000000)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc)
  );

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFFFFFC)) dut_wrap (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(w_inst_valid), .inst_ready(inst_ready),
    .inst_out(w_inst_out), .inst_pc(w_inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // memory model
  int          ready_pct;
  int          lat_min, lat_max;
  logic        mem_pending = 1'b0;
  int          mem_wait = 0;
  logic [31:0] mem_addr = '0;

  // per-cycle snapshot, taken mid-cycle
  logic        s_req, s_valid, s_rvalid, s_acc, s_xfer, s_wvalid;
  logic [31:0] s_addr, s_out, s_pc;

  // accepted requests and delivered instructions
  logic [31:0] aq_addr[$];
  int          aq_cyc[$];
  logic [31:0] dq_pc[$];
  logic [31:0] dq_inst[$];
  logic [31:0] dq_wpc[$];
  int          dq_cyc[$];

  task automatic clear_q();
    aq_addr.delete(); aq_cyc.delete();
    dq_pc.delete(); dq_inst.delete(); dq_wpc.delete(); dq_cyc.delete();
  endtask

  // One clock cycle: drive memory outputs, sample handshakes, take the edge,
  // then advance the memory model.
  task automatic tick();
    imem_ready  = ($urandom_range(99) < ready_pct);
    imem_rvalid = mem_pending && (mem_wait == 0);
    imem_rdata  = imem_rvalid ? (mem_addr + 32'h13) : $urandom;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = inst_valid;
    s_out = inst_out; s_pc = inst_pc; s_rvalid = imem_rvalid;
    s_wvalid = w_inst_valid;
    s_acc  = imem_req && imem_ready;
    s_xfer = inst_valid && inst_ready;
    if (s_acc) begin
      aq_addr.push_back(imem_addr);
      aq_cyc.push_back(cyc);
    end
    if (s_xfer) begin
      dq_pc.push_back(inst_pc);
      dq_inst.push_back(inst_out);
      dq_wpc.push_back(w_inst_pc);
      dq_cyc.push_back(cyc);
      $display("xfer cyc=%0d pc=%h inst=%h", cyc, inst_pc, inst_out);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      mem_pending = 1'b0;
    end else begin
      if (mem_pending) begin
        if (mem_wait == 0) mem_pending = 1'b0;
        else mem_wait--;
      end
      if (s_acc) begin
        mem_pending = 1'b1;
        mem_addr    = s_addr;
        mem_wait    = lat_min + int'($urandom_range(lat_max - lat_min));
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    ready_pct = 100; lat_min = 0; lat_max = 0;
    tick(); tick();
    rst = 1'b0;
    clear_q();
  endtask

  task automatic wait_deliveries(input int n, input int bound, output bit ok);
    int k = 0;
    while (dq_pc.size() < n && k < bound) begin
      tick();
      k++;
    end
    ok = (dq_pc.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    ready_pct = 100; lat_min = 0; lat_max = 0;
    tick();
    checks++;
    if (s_req !== 1'b0 || s_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake req=%b valid=%b required 0/0", s_req, s_valid);
    end
    tick();
    checks++;
    if (inst_out !== 32'h0 || inst_pc !== 32'h0 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_regs out=%h pc=%h addr=%h required 0/0/0", inst_out, inst_pc, imem_addr);
    end
    rst = 1'b0;
    clear_q();
    tick();
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h0 || s_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_req req=%b addr=%h valid=%b required 1/00000000/0", s_req, s_addr, s_valid);
    end
  endtask

  task automatic test_stream();
    bit ok;
    do_reset();
    wait_deliveries(4, 20, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stream_timeout got=%0d required 4 deliveries", dq_pc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (dq_pc[k] !== 32'(4 * k) || dq_inst[k] !== 32'(4 * k + 32'h13)) begin
          failures++;
          $display("FAIL stream_data[%0d] pc=%h inst=%h required %h/%h", k, dq_pc[k], dq_inst[k], 32'(4 * k), 32'(4 * k + 32'h13));
        end
        if (k > 0) begin
          checks++;
          if (dq_cyc[k] - dq_cyc[k-1] != 3) begin
            failures++;
            $display("FAIL stream_rate[%0d] spacing=%0d required 3", k, dq_cyc[k] - dq_cyc[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_mem_stall();
    bit ok;
    do_reset();
    ready_pct = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h0) begin
        failures++;
        $display("FAIL memstall_hold[%0d] req=%b addr=%h required 1/00000000", k, s_req, s_addr);
      end
    end
    ready_pct = 100; lat_min = 3; lat_max = 3;
    wait_deliveries(1, 20, ok);
    checks++;
    if (!ok || aq_addr.size() != 1 || aq_addr[0] !== 32'h0 ||
        dq_cyc[0] - aq_cyc[0] != 5 || dq_pc[0] !== 32'h0) begin
      failures++;
      $display("FAIL memstall_accept ok=%0d accepts=%0d latency=%0d required 1/1/5",
               ok, aq_addr.size(), ok && aq_cyc.size() > 0 ? dq_cyc[0] - aq_cyc[0] : -1);
    end
  endtask

  task automatic test_decode_stall();
    int k = 0;
    logic [31:0] v_out, v_pc;
    do_reset();
    inst_ready = 1'b0;
    tick();
    while (!s_valid && k < 10) begin
      tick();
      k++;
    end
    v_out = s_out; v_pc = s_pc;
    checks++;
    if (s_valid !== 1'b1 || v_pc !== 32'h0 || v_out !== 32'h13) begin
      failures++;
      $display("FAIL decstall_first valid=%b pc=%h out=%h required 1/00000000/00000013", s_valid, v_pc, v_out);
    end
    for (int j = 0; j < 5; j++) begin
      tick();
      checks++;
      if (s_valid !== 1'b1 || s_out !== v_out || s_pc !== v_pc || s_req !== 1'b0) begin
        failures++;
        $display("FAIL decstall_hold[%0d] valid=%b out=%h pc=%h req=%b required 1/%h/%h/0", j, s_valid, s_out, s_pc, s_req, v_out, v_pc);
      end
    end
    inst_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (dq_pc.size() != 1 || s_req !== 1'b1 || s_addr !== 32'h4) begin
      failures++;
      $display("FAIL decstall_release xfers=%0d req=%b addr=%h required 1/1/00000004", dq_pc.size(), s_req, s_addr);
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    do_reset();
    lat_min = 3; lat_max = 3;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000005E;
    tick();
    redirect_valid = 1'b0;
    wait_deliveries(1, 30, ok);
    checks++;
    if (!ok || dq_pc[0] !== 32'h5C || dq_inst[0] !== 32'h6F) begin
      failures++;
      $display("FAIL redir_wait_deliver ok=%0d pc=%h inst=%h required 0000005C/0000006F",
               ok, ok ? dq_pc[0] : 32'hx, ok ? dq_inst[0] : 32'hx);
    end
    checks++;
    if (aq_addr.size() != 2 || aq_addr[1] !== 32'h5C) begin
      failures++;
      $display("FAIL redir_wait_req accepts=%0d second_addr=%h required 2/0000005C",
               aq_addr.size(), aq_addr.size() > 1 ? aq_addr[1] : 32'hx);
    end
  endtask

  task automatic test_redirect_hold();
    bit ok;
    int k = 0;
    do_reset();
    inst_ready = 1'b0;
    tick();
    while (!s_valid && k < 10) begin
      tick();
      k++;
    end
    inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h00000100;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (s_valid !== 1'b0 || dq_pc.size() != 0) begin
      failures++;
      $display("FAIL redir_hold_kill valid=%b xfers=%0d required 0/0", s_valid, dq_pc.size());
    end
    tick();
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h100) begin
      failures++;
      $display("FAIL redir_hold_req req=%b addr=%h required 1/00000100", s_req, s_addr);
    end
    wait_deliveries(1, 20, ok);
    checks++;
    if (!ok || dq_pc[0] !== 32'h100 || dq_inst[0] !== 32'h113) begin
      failures++;
      $display("FAIL redir_hold_deliver ok=%0d pc=%h required 00000100", ok, ok ? dq_pc[0] : 32'hx);
    end
    // redirect landing on the response cycle
    do_reset();
    lat_min = 1; lat_max = 1;
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h00000203;
    tick();
    redirect_valid = 1'b0;
    wait_deliveries(1, 20, ok);
    checks++;
    if (!ok || dq_pc[0] !== 32'h200 || dq_inst[0] !== 32'h213) begin
      failures++;
      $display("FAIL redir_rvalid_drop ok=%0d pc=%h inst=%h required 00000200/00000213",
               ok, ok ? dq_pc[0] : 32'hx, ok ? dq_inst[0] : 32'hx);
    end
  endtask

  task automatic test_wrap_and_reset();
    bit ok;
    do_reset();
    wait_deliveries(2, 20, ok);
    checks++;
    if (!ok || dq_wpc[0] !== 32'hFFFFFFFC || dq_wpc[1] !== 32'h00000000) begin
      failures++;
      $display("FAIL wrap_pc ok=%0d pc0=%h pc1=%h required FFFFFFFC/00000000",
               ok, ok ? dq_wpc[0] : 32'hx, ok ? dq_wpc[1] : 32'hx);
    end
    // reset while a request is in flight
    do_reset();
    lat_min = 3; lat_max = 3;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_q();
    tick();
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h0 || s_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_wait_restart req=%b addr=%h valid=%b required 1/00000000/0", s_req, s_addr, s_valid);
    end
    wait_deliveries(1, 20, ok);
    checks++;
    if (!ok || aq_addr.size() != 1 || dq_cyc[0] - aq_cyc[0] != 5 || dq_pc[0] !== 32'h0) begin
      failures++;
      $display("FAIL rst_wait_deliver ok=%0d accepts=%0d required 1/1 with latency 5", ok, aq_addr.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] pc, inst;
    logic        p_valid = 1'b0, p_xfer = 1'b0;
    logic [31:0] p_out = '0, p_pc = '0;
    bit          rd;
    int          ndel = 0;
    do_reset();
    ready_pct = 60; lat_min = 0; lat_max = 3;
    for (int it = 0; it < 400; it++) begin
      rd = ($urandom_range(19) == 0);
      redirect_valid = rd;
      redirect_pc    = $urandom;
      inst_ready     = ($urandom_range(3) != 0);
      tick();
      if (p_valid && !p_xfer && !rd) begin
        checks++;
        if (s_valid !== 1'b1 || s_out !== p_out || s_pc !== p_pc) begin
          failures++;
          $display("FAIL rand_stable cyc=%0d valid=%b out=%h pc=%h required 1/%h/%h", cyc, s_valid, s_out, s_pc, p_out, p_pc);
        end
      end
      if (dq_pc.size() > 0) begin
        pc = dq_pc.pop_front(); inst = dq_inst.pop_front();
        void'(dq_wpc.pop_front()); void'(dq_cyc.pop_front());
        checks++;
        if (rd || pc !== exp_pc || inst !== pc + 32'h13) begin
          failures++;
          $display("FAIL rand_deliver cyc=%0d pc=%h inst=%h redirect=%0d required %h/%h", cyc, pc, inst, rd, exp_pc, exp_pc + 32'h13);
        end
        exp_pc = exp_pc + 32'h4;
        ndel++;
      end
      if (rd) exp_pc = redirect_pc & 32'hFFFFFFFC;
      p_valid = s_valid; p_xfer = s_xfer; p_out = s_out; p_pc = s_pc;
    end
    redirect_valid = 1'b0;
    checks++;
    if (ndel < 20) begin
      failures++;
      $display("FAIL rand_progress deliveries=%0d required at least 20", ndel);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_mem_stall();
    test_decode_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch unit: the consumer side of the program counter. It owns the fetch address, reads instruction words from an instruction memory over a request/response handshake with one request outstanding, and presents each fetched word with its address to decode over a valid/ready handshake. It sits between the PC/next-PC logic (redirect input) and the instruction memory, and makes the core tolerant of a multi-cycle instruction memory.

## Interface
- XLEN, 32, address and instruction width
- RESET_PC, 32'h00000000, first fetch address after reset
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- redirect_valid  input  1  branch/jump taken; replaces fetch address
- redirect_pc  input  XLEN  redirect target; bits [1:0] ignored (forced 00)
- imem_req  output  1  fetch request
- imem_addr  output  XLEN  fetch address, word aligned
- imem_ready  input  1  memory accepts request this cycle
- imem_rvalid  input  1  response data valid
- imem_rdata  input  XLEN  instruction word
- inst_valid  output  1  instruction available to decode
- inst_ready  input  1  decode accepts instruction
- inst_out  output  XLEN  fetched instruction
- inst_pc  output  XLEN  address of inst_out

## Operation
- Registers: fetch_pc, state, drop, inst_out, inst_pc.
- States: REQ (issue request), WAIT (request accepted, awaiting response), HOLD (instruction buffered, awaiting decode).
- REQ: imem_req = !redirect_valid; imem_addr = fetch_pc. If redirect_valid: fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}, stay REQ. Else if imem_ready: go WAIT.
- WAIT: imem_req = 0. On imem_rvalid with drop=0 and no redirect: inst_out <= imem_rdata, inst_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (mod 2^XLEN, 32'hFFFFFFFC wraps to 0), go HOLD. On imem_rvalid with drop=1 or redirect_valid: discard data, drop <= 0, go REQ. redirect_valid without rvalid: fetch_pc <= redirect target, drop <= 1, stay WAIT.
- HOLD: inst_valid = !redirect_valid. Transfer when inst_valid && inst_ready: go REQ. redirect_valid: buffer discarded (no transfer even if inst_ready=1), fetch_pc <= redirect target, go REQ.
- imem_rvalid outside WAIT is ignored.
- Redirect has priority over every other event in every state.
- inst_out/inst_pc hold stable while inst_valid=1.

## Timing
- Reset: state=REQ, fetch_pc=RESET_PC, drop=0, inst_out=0, inst_pc=0; imem_req=0 and inst_valid=0 during any cycle rst=1.
- rst overrides everything, including mid-WAIT/HOLD; buffered instruction and pending drop lost. Memory shares rst, so no stale response crosses reset.
- First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC.
- imem_req/inst_valid are combinational from state and redirect_valid; all else registered.
- Response earliest one cycle after acceptance. Zero-wait memory, always-ready decode: one instruction per 3 cycles (REQ, WAIT, HOLD).
- Latency from accepted request to inst_valid: response cycle + 1.
- Redirect in REQ: new address on imem_addr the next cycle. Redirect in WAIT: one in-flight response dropped, then REQ with new address.

## Test plan
- Reset then zero-wait memory returning addr+32'h13, inst_ready=1 -> inst_pc sequence 0,4,8,C with inst_out 13,17,1B,1F, one instruction per 3 cycles.
- imem_ready low 4 cycles in REQ, then response delayed 3 cycles -> imem_addr held stable, exactly one accept, inst_valid after response edge.
- inst_ready low 5 cycles in HOLD -> inst_valid/inst_out/inst_pc stable, no new imem_req until transfer.
- redirect_valid to 32'h0000005E during WAIT -> response for old pc discarded, next request addr 32'h0000005C, delivered inst_pc=5C.
- redirect in HOLD with inst_ready=1 same cycle -> inst_valid low that cycle, no transfer, next request at redirect target; redirect coincident with rvalid in WAIT -> data dropped.
- RESET_PC=32'hFFFFFFFC, fetch two instructions -> inst_pc FFFFFFFC then 00000000; assert rst mid-WAIT -> restart at RESET_PC, no inst_valid from pre-reset request.
